// File: rtl/circuito_exp3_ativ2_core_pkg.sv
// ============================================================================
// circuito_exp3_ativ2_core_pkg
// Shared width and terminal-count constants for the counter/comparator core.
// Rev 1.0
// ============================================================================
`default_nettype none

package circuito_exp3_ativ2_core_pkg;

  localparam int unsigned C_WIDTH = 4;

  // All-ones value of a w-bit count, i.e. (1<<w)-1.
  function automatic int unsigned terminal_value(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  localparam int unsigned C_TERMINAL = terminal_value(C_WIDTH);

endpackage

`default_nettype wire

// File: rtl/comparador_4b.sv
// ============================================================================
// comparador_4b
// Unsigned magnitude comparator producing one-hot less/greater/equal flags.
// Rev 1.0
// ============================================================================
`default_nettype none

module comparador_4b
  import circuito_exp3_ativ2_core_pkg::*;
#(
  parameter int unsigned N = C_WIDTH
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         menor,
  output logic         maior,
  output logic         igual
);

  assign menor = (A < B);
  assign maior = (A > B);
  assign igual = (A == B);

endmodule

`default_nettype wire

// File: rtl/contador_4b.sv
// ============================================================================
// contador_4b
// Loadable binary up-counter: async clear, sync clear > load > increment.
// Rev 1.0
// ============================================================================
`default_nettype none

module contador_4b
  import circuito_exp3_ativ2_core_pkg::*;
#(
  parameter int unsigned N = C_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         zera,
  input  logic         carrega,
  input  logic         conta,
  input  logic [N-1:0] D,
  output logic [N-1:0] Q,
  output logic         rco
);

  logic [N-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (zera) begin
      r_count <= '0;
    end else if (carrega) begin
      r_count <= D;
    end else if (conta) begin
      r_count <= r_count + 1'b1;  // natural wrap from all-ones to zero
    end
  end

  assign Q   = r_count;
  // Terminal count is decoded from the state alone, not gated by conta.
  assign rco = (r_count == {N{1'b1}});

endmodule

`default_nettype wire

// File: rtl/circuito_exp3_ativ2_core.sv
// ============================================================================
// circuito_exp3_ativ2_core
// Counter/comparator datapath: counter output compared against the switches.
// Rev 1.0
// ============================================================================
`default_nettype none

module circuito_exp3_ativ2_core
  import circuito_exp3_ativ2_core_pkg::*;
#(
  parameter int unsigned N = C_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         zera,
  input  logic         carrega,
  input  logic         conta,
  input  logic [N-1:0] chaves,
  output logic         menor,
  output logic         maior,
  output logic         igual,
  output logic         fim,
  output logic [N-1:0] db_contagem
);

  logic [N-1:0] w_count;

  contador_4b #(.N(N)) u_contador (
    .clk     (clk),
    .rst_n   (rst_n),
    .zera    (zera),
    .carrega (carrega),
    .conta   (conta),
    .D       (chaves),
    .Q       (w_count),
    .rco     (fim)
  );

  comparador_4b #(.N(N)) u_comparador (
    .A     (w_count),
    .B     (chaves),
    .menor (menor),
    .maior (maior),
    .igual (igual)
  );

  assign db_contagem = w_count;

endmodule

`default_nettype wire

// File: tb/tb_circuito_exp3_ativ2_core.sv
// ============================================================================
// tb_circuito_exp3_ativ2_core
// Directed and randomized checks of the counter/comparator core.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_circuito_exp3_ativ2_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       zera, carrega, conta;
  logic [3:0] chaves;
  logic       menor, maior, igual, fim;
  logic [3:0] db_contagem;

  int n_checks = 0;
  int n_fail   = 0;
  int model;  // expected count as a plain integer 0..15

  circuito_exp3_ativ2_core #(.N(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .zera        (zera),
    .carrega     (carrega),
    .conta       (conta),
    .chaves      (chaves),
    .menor       (menor),
    .maior       (maior),
    .igual       (igual),
    .fim         (fim),
    .db_contagem (db_contagem)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Compare every output against the integer model and current switches.
  task automatic check_all(input string tag);
    int sw;
    sw = int'(chaves);
    check_eq({tag, ".count"}, int'(db_contagem), model);
    check_eq({tag, ".fim"},   int'(fim),   (model == 15) ? 1 : 0);
    check_eq({tag, ".menor"}, int'(menor), (model < sw) ? 1 : 0);
    check_eq({tag, ".maior"}, int'(maior), (model > sw) ? 1 : 0);
    check_eq({tag, ".igual"}, int'(igual), (model == sw) ? 1 : 0);
  endtask

  // One rising edge; the model applies the priority rules arithmetically.
  task automatic tick();
    int sw;
    sw = int'(chaves);
    @(posedge clk);
    if (zera)         model = 0;
    else if (carrega) model = sw;
    else if (conta)   model = (model + 1) % 16;
    #1;
  endtask

  task automatic set_ctl(input logic z, input logic c, input logic k);
    zera = z; carrega = c; conta = k;
  endtask

  initial begin
    rst_n = 1'b0; chaves = 4'd0; set_ctl(0, 0, 0);
    model = 0;
    #12;
    check_all("reset");
    check_eq("reset.fim0", int'(fim), 0);
    check_eq("reset.igual1", int'(igual), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    set_ctl(1, 0, 0); tick(); check_all("zera");
    set_ctl(0, 0, 0);

    chaves = 4'b0001; #1;
    check_eq("nocl.menor", int'(menor), 1);
    set_ctl(0, 0, 1); tick(); check_all("cnt1");
    check_eq("cnt1.value", int'(db_contagem), 1);
    tick(); tick();
    check_eq("cnt3.value", int'(db_contagem), 3);
    set_ctl(0, 0, 0);
    chaves = 4'b0010; #1; check_eq("sw2.maior", int'(maior), 1);
    chaves = 4'b0110; #1; check_eq("sw6.menor", int'(menor), 1);

    set_ctl(0, 0, 1);
    for (int i = 0; i < 11; i++) tick();
    check_eq("c14.value", int'(db_contagem), 14);
    check_eq("c14.fim", int'(fim), 0);
    check_eq("c14.maior", int'(maior), 1);
    tick();
    check_eq("c15.value", int'(db_contagem), 15);
    check_eq("c15.fim", int'(fim), 1);
    tick();
    check_eq("wrap.value", int'(db_contagem), 0);
    check_eq("wrap.fim", int'(fim), 0);

    chaves = 4'b1010; set_ctl(0, 1, 0); tick();
    check_eq("load.value", int'(db_contagem), 10);
    check_eq("load.igual", int'(igual), 1);
    set_ctl(0, 1, 1); tick();
    check_eq("loadcnt.value", int'(db_contagem), 10);
    set_ctl(1, 0, 1); tick();
    check_eq("zeracnt.value", int'(db_contagem), 0);

    chaves = 4'b0111; set_ctl(0, 1, 0); tick();
    set_ctl(0, 0, 0);
    check_eq("pre_arst.value", int'(db_contagem), 7);
    #2 rst_n = 1'b0; #1;
    model = 0;
    check_eq("arst.value", int'(db_contagem), 0);
    check_all("arst");
    #1 rst_n = 1'b1;
    tick(); check_all("post_arst");

    // Randomized phase with occasional mid-cycle asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      chaves  = 4'($urandom_range(0, 15));
      zera    = ($urandom_range(0, 15) == 0);
      carrega = ($urandom_range(0, 7) == 0);
      conta   = ($urandom_range(0, 3) != 0);
      #1; check_all("rnd.pre");
      tick(); check_all("rnd.post");
      if ($urandom_range(0, 39) == 0) begin
        #1 rst_n = 1'b0; #1;
        model = 0;
        check_all("rnd.arst");
        #1 rst_n = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
